// File: rtl/rv_decode_queue.sv
// rv_decode_queue: RV64IM decode stage that turns LANES-wide fetch bundles into a DEPTH-entry micro-op FIFO.
// Optional feature macro RV_DECODE_M_EN: when defined, funct7=0x01 under OP/OP-32 decodes as MULDIV.

module rv_decode_queue #(
    parameter int XLEN  = 64,
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [XLEN-1:0]              in_pc,
    input  logic [32*LANES-1:0]          in_insn,
    input  logic [LANES-1:0]             in_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [31:0]                  out_insn,
    output logic [3:0]                   out_class,
    output logic [4:0]                   out_funct,
    output logic                         out_word,
    output logic [4:0]                   out_rd,
    output logic [4:0]                   out_rs1,
    output logic [4:0]                   out_rs2,
    output logic [XLEN-1:0]              out_imm,
    output logic [XLEN-1:0]              out_target,
    output logic [$clog2(DEPTH+1)-1:0]   out_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;

    typedef enum logic [3:0] {
        CL_OP      = 4'd0,
        CL_OPIMM   = 4'd1,
        CL_LOAD    = 4'd2,
        CL_STORE   = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_JAL     = 4'd5,
        CL_JALR    = 4'd6,
        CL_LUI     = 4'd7,
        CL_AUIPC   = 4'd8,
        CL_SYSTEM  = 4'd9,
        CL_MULDIV  = 4'd10,
        CL_FENCE   = 4'd11,
        CL_ILLEGAL = 4'd15
    } uop_class_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        uop_class_e      cls;
        logic [4:0]      funct;
        logic            word;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
    } uop_t;

    // Illegal encodings keep only pc and raw insn so nothing downstream sees stale fields.
    function automatic uop_t decodeInsn(input logic [31:0] insn, input logic [XLEN-1:0] pc);
        uop_t            u;
        logic [6:0]      opc;
        logic [6:0]      f7;
        logic [2:0]      f3;
        logic            bad;
        logic [XLEN-1:0] immI;
        logic [XLEN-1:0] immS;
        logic [XLEN-1:0] immB;
        logic [XLEN-1:0] immU;
        logic [XLEN-1:0] immJ;
        opc  = insn[6:0];
        f7   = insn[31:25];
        f3   = insn[14:12];
        bad  = 1'b0;
        immI = {{(XLEN-12){insn[31]}}, insn[31:20]};
        immS = {{(XLEN-12){insn[31]}}, insn[31:25], insn[11:7]};
        immB = {{(XLEN-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        immU = {{(XLEN-32){insn[31]}}, insn[31:12], 12'b0};
        immJ = {{(XLEN-21){insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        u       = '0;
        u.pc    = pc;
        u.insn  = insn;
        u.funct = {insn[30], insn[25], f3};
        case (opc)
            OPC_OP, OPC_OP32: begin
                u.word = (opc == OPC_OP32);
                u.rd   = insn[11:7];
                u.rs1  = insn[19:15];
                u.rs2  = insn[24:20];
                u.cls  = CL_OP;
                if (f7 == 7'h20) begin
                    bad = (f3 != 3'b000) && (f3 != 3'b101);
                end else if (f7 == 7'h01) begin
`ifdef RV_DECODE_M_EN
                    u.cls = CL_MULDIV;
`else
                    bad = 1'b1;
`endif
                end else if (f7 != 7'h00) begin
                    bad = 1'b1;
                end
            end
            OPC_OPIMM, OPC_OPIMM32: begin
                u.word = (opc == OPC_OPIMM32);
                u.cls  = CL_OPIMM;
                u.rd   = insn[11:7];
                u.rs1  = insn[19:15];
                u.imm  = immI;
            end
            OPC_LOAD: begin
                u.cls = CL_LOAD;
                u.rd  = insn[11:7];
                u.rs1 = insn[19:15];
                u.imm = immI;
                bad   = (f3 == 3'b111);
            end
            OPC_STORE: begin
                u.cls = CL_STORE;
                u.rs1 = insn[19:15];
                u.rs2 = insn[24:20];
                u.imm = immS;
                bad   = f3[2];
            end
            OPC_BRANCH: begin
                u.cls = CL_BRANCH;
                u.rs1 = insn[19:15];
                u.rs2 = insn[24:20];
                u.imm = immB;
                bad   = (f3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                u.cls = CL_JAL;
                u.rd  = insn[11:7];
                u.imm = immJ;
            end
            OPC_JALR: begin
                u.cls = CL_JALR;
                u.rd  = insn[11:7];
                u.rs1 = insn[19:15];
                u.imm = immI;
                bad   = (f3 != 3'b000);
            end
            OPC_LUI, OPC_AUIPC: begin
                u.cls = (opc == OPC_LUI) ? CL_LUI : CL_AUIPC;
                u.rd  = insn[11:7];
                u.imm = immU;
            end
            OPC_SYSTEM, OPC_FENCE: begin
                u.cls = (opc == OPC_SYSTEM) ? CL_SYSTEM : CL_FENCE;
                u.rd  = insn[11:7];
                u.rs1 = insn[19:15];
                u.imm = immI;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            u      = '0;
            u.pc   = pc;
            u.insn = insn;
            u.cls  = CL_ILLEGAL;
        end else if ((u.cls == CL_BRANCH) || (u.cls == CL_JAL)) begin
            u.target = pc + u.imm;
        end
        return u;
    endfunction

    uop_t            mem_q [DEPTH];
    logic [PW-1:0]   wrPtr_q, wrPtr_d;
    logic [PW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;

    uop_t            laneDec [LANES];
    logic [PW-1:0]   laneOff [LANES];
    logic [CW-1:0]   pushCnt;
    logic            pushEn;
    logic            popEn;
    uop_t            headUop;

    assign out_valid = (count_q != '0);
    assign in_ready  = ((CW'(DEPTH) - count_q) >= CW'(LANES));
    assign pushEn    = in_valid && in_ready && !flush;
    assign popEn     = out_valid && out_ready && !flush;

    // Each set lane lands at wrPtr + (number of set lanes below it), packing the bundle contiguously.
    always_comb begin
        laneOff[0] = '0;
        for (int i = 0; i < LANES; i++) begin
            laneDec[i] = decodeInsn(in_insn[32*i +: 32], in_pc + XLEN'(4 * i));
        end
        for (int i = 1; i < LANES; i++) begin
            laneOff[i] = laneOff[i-1] + PW'(in_mask[i-1]);
        end
        pushCnt = pushEn ? (CW'(laneOff[LANES-1]) + CW'(in_mask[LANES-1])) : '0;
    end

    always_comb begin
        wrPtr_d = wrPtr_q + PW'(pushCnt);
        rdPtr_d = rdPtr_q + PW'(popEn);
        count_d = count_q + pushCnt - CW'(popEn);
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked by out_valid, which is derived from the reset count.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            for (int i = 0; i < LANES; i++) begin
                if (in_mask[i]) begin
                    mem_q[wrPtr_q + laneOff[i]] <= laneDec[i];
                end
            end
        end
    end

    assign headUop    = out_valid ? mem_q[rdPtr_q] : '0;
    assign out_pc     = headUop.pc;
    assign out_insn   = headUop.insn;
    assign out_class  = headUop.cls;
    assign out_funct  = headUop.funct;
    assign out_word   = headUop.word;
    assign out_rd     = headUop.rd;
    assign out_rs1    = headUop.rs1;
    assign out_rs2    = headUop.rs2;
    assign out_imm    = headUop.imm;
    assign out_target = headUop.target;
    assign out_count  = count_q;

endmodule

// File: tb/tb_rv_decode_queue.sv
// Scoreboard bench for rv_decode_queue (LANES=2, DEPTH=4): directed vectors with hand-computed decode results.
// Expected MULDIV behaviour follows the RV_DECODE_M_EN macro.

module tb_rv_decode_queue;

    localparam int XLEN  = 64;
    localparam int LANES = 2;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [63:0]       in_insn;
    logic [1:0]        in_mask;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_insn;
    logic [3:0]        out_class;
    logic [4:0]        out_funct;
    logic              out_word;
    logic [4:0]        out_rd;
    logic [4:0]        out_rs1;
    logic [4:0]        out_rs2;
    logic [XLEN-1:0]   out_imm;
    logic [XLEN-1:0]   out_target;
    logic [2:0]        out_count;

    typedef struct packed {
        logic [31:0] insn;
        logic [3:0]  cls;
        logic [4:0]  funct;
        logic        word;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic        tgt;
    } vec_t;

    typedef struct packed {
        logic [63:0] pc;
        vec_t        v;
    } exp_t;

    vec_t  vecs [23];
    exp_t  sb [$];
    int    checks = 0;
    int    errors = 0;

    int         bunA [11] = '{1, 4, 6, 8, 10, 12, 2, 22, 15, 17, 19};
    int         bunB [11] = '{3, 5, 7, 9, 11, 13, 21, 14, 16, 18, 20};
    logic [1:0] bunM [11] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};

    rv_decode_queue #(.XLEN(XLEN), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_insn(in_insn), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_insn(out_insn),
        .out_class(out_class), .out_funct(out_funct), .out_word(out_word),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_target(out_target), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkVec(input logic [31:0] insn, input logic [3:0] cls, input logic [4:0] funct,
                                   input logic word, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [63:0] imm, input logic tgt);
        vec_t v;
        v.insn = insn; v.cls = cls; v.funct = funct; v.word = word;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.tgt = tgt;
        return v;
    endfunction

    task automatic initVectors();
        vecs[0]  = mkVec(32'h00B50533, 4'd0,  5'b00000, 1'b0, 5'd10, 5'd10, 5'd11, 64'h0, 1'b0);
        vecs[1]  = mkVec(32'hFE000EE3, 4'd4,  5'b11000, 1'b0, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
`ifdef RV_DECODE_M_EN
        vecs[2]  = mkVec(32'h02B50533, 4'd10, 5'b01000, 1'b0, 5'd10, 5'd10, 5'd11, 64'h0, 1'b0);
`else
        vecs[2]  = mkVec(32'h02B50533, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
`endif
        vecs[3]  = mkVec(32'h800002B7, 4'd7,  5'b00000, 1'b0, 5'd5,  5'd0,  5'd0,  64'hFFFF_FFFF_8000_0000, 1'b0);
        vecs[4]  = mkVec(32'h00813183, 4'd2,  5'b00011, 1'b0, 5'd3,  5'd2,  5'd0,  64'h8, 1'b0);
        vecs[5]  = mkVec(32'hFE513C23, 4'd3,  5'b11011, 1'b0, 5'd0,  5'd2,  5'd5,  64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        vecs[6]  = mkVec(32'h010000EF, 4'd5,  5'b00000, 1'b0, 5'd1,  5'd0,  5'd0,  64'h10, 1'b1);
        vecs[7]  = mkVec(32'h0010809B, 4'd1,  5'b00000, 1'b1, 5'd1,  5'd1,  5'd0,  64'h1, 1'b0);
        vecs[8]  = mkVec(32'h403100B3, 4'd0,  5'b10000, 1'b0, 5'd1,  5'd2,  5'd3,  64'h0, 1'b0);
        vecs[9]  = mkVec(32'h403100BB, 4'd0,  5'b10000, 1'b1, 5'd1,  5'd2,  5'd3,  64'h0, 1'b0);
        vecs[10] = mkVec(32'h00000073, 4'd9,  5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[11] = mkVec(32'h0FF0000F, 4'd11, 5'b01000, 1'b0, 5'd0,  5'd0,  5'd0,  64'hFF, 1'b0);
        vecs[12] = mkVec(32'h00001217, 4'd8,  5'b00001, 1'b0, 5'd4,  5'd0,  5'd0,  64'h1000, 1'b0);
        vecs[13] = mkVec(32'h004100E7, 4'd6,  5'b00000, 1'b0, 5'd1,  5'd2,  5'd0,  64'h4, 1'b0);
        vecs[14] = mkVec(32'h00000000, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[15] = mkVec(32'h403110B3, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[16] = mkVec(32'h00009067, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[17] = mkVec(32'h00007003, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[18] = mkVec(32'h00002063, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[19] = mkVec(32'h00004023, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[20] = mkVec(32'h04000033, 4'd15, 5'b00000, 1'b0, 5'd0,  5'd0,  5'd0,  64'h0, 1'b0);
        vecs[21] = mkVec(32'h4030D093, 4'd1,  5'b10101, 1'b0, 5'd1,  5'd1,  5'd0,  64'h403, 1'b0);
        vecs[22] = mkVec(32'h0020C463, 4'd4,  5'b00100, 1'b0, 5'd0,  5'd1,  5'd2,  64'h8, 1'b1);
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [63:0] expTgt;
        expTgt = e.v.tgt ? (e.pc + e.v.imm) : 64'h0;
        cmp("out_pc", out_pc, e.pc);
        cmp("out_insn", {32'h0, out_insn}, {32'h0, e.v.insn});
        cmp("out_class", {60'h0, out_class}, {60'h0, e.v.cls});
        cmp("out_imm", out_imm, e.v.imm);
        cmp("out_target", out_target, expTgt);
        if (e.v.cls != 4'd15) begin
            cmp("out_funct", {59'h0, out_funct}, {59'h0, e.v.funct});
            cmp("out_word", {63'h0, out_word}, {63'h0, e.v.word});
            cmp("out_rd", {59'h0, out_rd}, {59'h0, e.v.rd});
            cmp("out_rs1", {59'h0, out_rs1}, {59'h0, e.v.rs1});
            cmp("out_rs2", {59'h0, out_rs2}, {59'h0, e.v.rs2});
        end
    endtask

    // Monitor: every handshake pop is matched against the oldest expected micro-op.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got pc %h expected no output", out_pc);
            end else begin
                checkOutput(sb.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] pc, input int a, input int b, input logic [1:0] mask);
        int   n;
        exp_t e;
        in_pc    = pc;
        in_insn  = {vecs[b].insn, vecs[a].insn};
        in_mask  = mask;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
        end else begin
            if (mask[0]) begin e.pc = pc;     e.v = vecs[a]; sb.push_back(e); end
            if (mask[1]) begin e.pc = pc + 4; e.v = vecs[b]; sb.push_back(e); end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mask  = 2'b00;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (out_count != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        cmp("drain_count", {61'h0, out_count}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        initVectors();
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_insn   = '0;
        in_mask   = '0;
        out_ready = 1'b0;
        #2;
        cmp("reset_out_valid", {63'h0, out_valid}, 64'h0);
        cmp("reset_in_ready", {63'h0, in_ready}, 64'h1);
        cmp("reset_count", {61'h0, out_count}, 64'h0);
        cmp("reset_out_pc", out_pc, 64'h0);
        cmp("reset_out_imm", out_imm, 64'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Single-lane push and one-cycle latency
        cmp("idle_out_valid", {63'h0, out_valid}, 64'h0);
        applyStimulus(64'h1000, 0, 0, 2'b01);
        cmp("latency_out_valid", {63'h0, out_valid}, 64'h1);
        cmp("latency_count", {61'h0, out_count}, 64'h1);
        drain();

        // Lane ordering with consumer always ready
        out_ready = 1'b1;
        applyStimulus(64'h2000, 0, 4, 2'b11);
        cmp("lane0_valid", {63'h0, out_valid}, 64'h1);
        cmp("lane0_pc", out_pc, 64'h2000);
        @(posedge clk); #1;
        cmp("lane1_pc", out_pc, 64'h2004);
        @(posedge clk); #1;
        cmp("pair_empty", {63'h0, out_valid}, 64'h0);
        applyStimulus(64'h2000, 0, 4, 2'b10);
        cmp("mask10_pc", out_pc, 64'h2004);
        cmp("mask10_count", {61'h0, out_count}, 64'h1);
        @(posedge clk); #1;
        cmp("mask10_empty", {63'h0, out_valid}, 64'h0);

        // Streaming decode of the vector table
        for (int k = 0; k < 11; k++) begin
            applyStimulus(64'h1000 + 64'(8 * k), bunA[k], bunB[k], bunM[k]);
        end
        applyStimulus(64'h1058, 0, 0, 2'b00);
        drain();
        cmp("stream_sb_empty", 64'(sb.size()), 64'h0);

        // Fill to DEPTH with consumer stalled
        applyStimulus(64'h3000, 8, 9, 2'b11);
        applyStimulus(64'h3008, 3, 12, 2'b11);
        cmp("full_count", {61'h0, out_count}, 64'h4);
        cmp("full_in_ready", {63'h0, in_ready}, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        cmp("stall_pc", out_pc, 64'h3000);
        cmp("stall_insn", {32'h0, out_insn}, {32'h0, vecs[8].insn});
        cmp("stall_count", {61'h0, out_count}, 64'h4);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        cmp("pop1_count", {61'h0, out_count}, 64'h3);
        cmp("pop1_in_ready", {63'h0, in_ready}, 64'h0);
        cmp("pop1_pc", out_pc, 64'h3004);

        // Flush beats a simultaneous push, both when full-ish and when ready
        in_pc = 64'h7000; in_insn = {vecs[0].insn, vecs[0].insn}; in_mask = 2'b11;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; in_mask = 2'b00;
        sb.delete();
        cmp("flush3_count", {61'h0, out_count}, 64'h0);
        cmp("flush3_valid", {63'h0, out_valid}, 64'h0);
        applyStimulus(64'h4000, 0, 0, 2'b01);
        in_pc = 64'h7100; in_insn = {vecs[4].insn, vecs[4].insn}; in_mask = 2'b11;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; in_mask = 2'b00;
        sb.delete();
        cmp("flush1_count", {61'h0, out_count}, 64'h0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("flush1_valid", {63'h0, out_valid}, 64'h0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a drain
        applyStimulus(64'h5000, 0, 4, 2'b11);
        applyStimulus(64'h5008, 5, 6, 2'b11);
        out_ready = 1'b1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        cmp("async_out_valid", {63'h0, out_valid}, 64'h0);
        cmp("async_count", {61'h0, out_count}, 64'h0);
        cmp("async_in_ready", {63'h0, in_ready}, 64'h1);
        cmp("async_out_pc", out_pc, 64'h0);
        sb.delete();
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Normal operation after reset
        applyStimulus(64'h6000, 22, 13, 2'b11);
        drain();
        cmp("final_sb_empty", 64'(sb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
